// File: rtl/tlul_host_reg_adapter.sv
// Single-word register host port to TL-UL initiator, one outstanding access with optional D timeout.
// Optional D-beat source/size/opcode checking enabled by defining TLUL_HOST_RSP_CHK_EN.

package tlul_pkg;
   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_SZW = 2;
   localparam int TL_DBW = TL_DW / 8;
   localparam int TL_AUW = 16;
   localparam int TL_DUW = 16;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic              a_valid;
      logic [2:0]        a_opcode;
      logic [2:0]        a_param;
      logic [TL_SZW-1:0] a_size;
      logic [TL_AIW-1:0] a_source;
      logic [TL_AW-1:0]  a_address;
      logic [TL_DBW-1:0] a_mask;
      logic [TL_DW-1:0]  a_data;
      logic [TL_AUW-1:0] a_user;
      logic              d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic              d_valid;
      logic [2:0]        d_opcode;
      logic [2:0]        d_param;
      logic [TL_SZW-1:0] d_size;
      logic [TL_AIW-1:0] d_source;
      logic [TL_DIW-1:0] d_sink;
      logic [TL_DW-1:0]  d_data;
      logic [TL_DUW-1:0] d_user;
      logic              d_error;
      logic              a_ready;
   } tl_d2h_t;
endpackage

module tlul_host_reg_adapter
   import tlul_pkg::*;
#(
   parameter int          AW            = 32,
   parameter int          DW            = 32,
   parameter int unsigned SourceId      = 0,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_i,
   output logic            gnt_o,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [DW-1:0]   wdata_i,
   input  logic [DW/8-1:0] be_i,
   output logic            valid_o,
   output logic [DW-1:0]   rdata_o,
   output logic            err_o,
   output logic            busy_o,
   output logic            rsp_err_o,
   output tl_h2d_t         tl_o,
   input  tl_d2h_t         tl_i
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] AREQ  = 3'd1;
   localparam logic [2:0] ARSP  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] LERR  = 3'd4;

   localparam int CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

   logic [2:0]      state_q, state_d;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] be_q;
   logic [CW-1:0]   cnt_q;
   logic            valid_q, err_q;
   logic [DW-1:0]   rdata_q;

   logic            local_err, a_fire, d_take, timeout_hit, chk_fail, rsp_bad;
   logic [AW-1:0]   addr_aligned;

   assign gnt_o     = req_i & (state_q == IDLE);
   assign busy_o    = (state_q != IDLE);
   assign local_err = we_i & (be_i == '0);
   assign a_fire    = (state_q == AREQ) & tl_i.a_ready;
   assign d_take    = (state_q == ARSP) & tl_i.d_valid;

   // A valid D beat in the firing cycle takes precedence over the timeout.
   assign timeout_hit = (TimeoutCycles != 0) && (state_q == ARSP) && !tl_i.d_valid &&
                        (cnt_q == CW'(TimeoutCycles - 1));

`ifdef TLUL_HOST_RSP_CHK_EN
   logic rsp_err_q;

   assign chk_fail = (tl_i.d_source != TL_AIW'(SourceId)) ||
                     (tl_i.d_size != TL_SZW'(2)) ||
                     (tl_i.d_opcode != (we_q ? AccessAck : AccessAckData));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_err_q <= 1'b0;
      end else if (d_take && chk_fail) begin
         rsp_err_q <= 1'b1;
      end
   end

   assign rsp_err_o = rsp_err_q;

   logic unused_d;
   assign unused_d = ^{tl_i.d_param, tl_i.d_sink, tl_i.d_user};
`else
   assign chk_fail  = 1'b0;
   assign rsp_err_o = 1'b0;

   logic unused_d;
   assign unused_d = ^{tl_i.d_param, tl_i.d_sink, tl_i.d_user,
                       tl_i.d_opcode, tl_i.d_size, tl_i.d_source};
`endif

   assign rsp_bad = tl_i.d_error | chk_fail;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               state_d = local_err ? LERR : AREQ;
            end
         end
         AREQ: begin
            if (tl_i.a_ready) begin
               state_d = ARSP;
            end
         end
         ARSP: begin
            if (tl_i.d_valid) begin
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (tl_i.d_valid) begin
               state_d = IDLE;
            end
         end
         LERR:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= 1'b0;

         if (gnt_o) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
         end

         if (a_fire) begin
            cnt_q <= '0;
         end else if ((state_q == ARSP) && !tl_i.d_valid) begin
            cnt_q <= cnt_q + CW'(1);
         end

         if (gnt_o && local_err) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '1;
         end else if (d_take) begin
            valid_q <= 1'b1;
            err_q   <= rsp_bad;
            rdata_q <= (rsp_bad || we_q) ? '1 : DW'(tl_i.d_data);
         end else if (timeout_hit) begin
            valid_q <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '1;
         end
      end
   end

   assign valid_o = valid_q;
   assign err_o   = err_q;
   assign rdata_o = rdata_q;

   assign addr_aligned = {addr_q[AW-1:2], 2'b00};

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = (state_q == AREQ);
      tl_o.a_opcode  = !we_q ? Get : ((be_q == '1) ? PutFullData : PutPartialData);
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = TL_SZW'(2);
      tl_o.a_source  = TL_AIW'(SourceId);
      tl_o.a_address = TL_AW'(addr_aligned);
      tl_o.a_mask    = we_q ? TL_DBW'(be_q) : '1;
      tl_o.a_data    = we_q ? TL_DW'(wdata_q) : '0;
      tl_o.a_user    = '0;
      tl_o.d_ready   = (state_q == ARSP) || (state_q == DRAIN);
   end

endmodule

// File: tb/tb_tlul_host_reg_adapter.sv
// Directed plus randomized bench for tlul_host_reg_adapter with a transaction-level reference model.
// Responses are predicted from request/response parameters, not from the bridge's internal state.
module tb_tlul_host_reg_adapter;
   import tlul_pkg::*;

   localparam int T   = 8;
   localparam int SRC = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic        valid;
   logic [31:0] rdata;
   logic        err;
   logic        busy;
   logic        rsp_err;
   tl_h2d_t     tl_h2d;
   tl_d2h_t     tl_d2h = '0;

   int errors = 0;
   int checks = 0;
   logic sticky_exp = 1'b0;

   tlul_host_reg_adapter #(
      .AW(32), .DW(32), .SourceId(SRC), .TimeoutCycles(T)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
      .addr_i(addr), .wdata_i(wdata), .be_i(be), .valid_o(valid),
      .rdata_o(rdata), .err_o(err), .busy_o(busy), .rsp_err_o(rsp_err),
      .tl_o(tl_h2d), .tl_i(tl_d2h)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete host access; the slave side is scripted by a_stall/d_delay.
   // d_delay is the D-channel cycle (0 = first cycle after A accept) carrying d_valid.
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input int a_stall, input int d_delay,
                          input logic [31:0] dd, input logic de, input int srcoff);
      logic [2:0]  exp_op;
      logic [3:0]  exp_mask;
      logic [31:0] exp_data, exp_rdata;
      logic        exp_err, timed_out, bad;
      int          resp_at, last;

      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = wd; be = b;
      @(negedge clk);
      check("gnt", gnt, 1'b1);
      check("busy_idle", busy, 1'b0);
      @(posedge clk); #1;
      req = 1'b0; we = $urandom; addr = $urandom; wdata = $urandom; be = 4'($urandom);

      if (w && b == 4'h0) begin
         @(negedge clk);
         check("lerr_valid", valid, 1'b1);
         check("lerr_err", err, 1'b1);
         check("lerr_rdata", rdata, 32'hFFFF_FFFF);
         check("lerr_no_a", tl_h2d.a_valid, 1'b0);
         @(negedge clk);
         check("lerr_pulse", valid, 1'b0);
         check("lerr_busy", busy, 1'b0);
         check("lerr_no_a2", tl_h2d.a_valid, 1'b0);
         return;
      end

      exp_op   = !w ? 3'h4 : ((b == 4'hF) ? 3'h0 : 3'h1);
      exp_mask = w ? b : 4'hF;
      exp_data = w ? wd : 32'h0;

      for (int k = 0; k <= a_stall; k++) begin
         tl_d2h.a_ready = (k == a_stall);
         @(negedge clk);
         check("a_valid", tl_h2d.a_valid, 1'b1);
         check("a_address", tl_h2d.a_address, a & 32'hFFFF_FFFC);
         check("a_opcode", tl_h2d.a_opcode, exp_op);
         check("a_mask", tl_h2d.a_mask, exp_mask);
         check("a_data", tl_h2d.a_data, exp_data);
         check("a_size", tl_h2d.a_size, 2'd2);
         check("a_source", tl_h2d.a_source, SRC);
         check("a_param_user", {tl_h2d.a_param, tl_h2d.a_user}, '0);
         check("a_phase_quiet", {valid, tl_h2d.d_ready}, 2'b00);
         @(posedge clk); #1;
      end
      tl_d2h.a_ready = 1'b0;

`ifdef TLUL_HOST_RSP_CHK_EN
      bad = (srcoff != 0);
`else
      bad = 1'b0;
`endif
      timed_out = !(d_delay >= 0 && d_delay < T);
      resp_at   = timed_out ? T : d_delay + 1;
      last      = (d_delay > resp_at) ? d_delay : resp_at;
      exp_err   = timed_out | de | bad;
      exp_rdata = (exp_err || w) ? 32'hFFFF_FFFF : dd;

      for (int j = 0; j <= last; j++) begin
         tl_d2h.d_valid  = (j == d_delay);
         tl_d2h.d_data   = (j == d_delay) ? dd : $urandom;
         tl_d2h.d_error  = (j == d_delay) ? de : 1'b0;
         tl_d2h.d_opcode = w ? 3'h0 : 3'h1;
         tl_d2h.d_size   = 2'd2;
         tl_d2h.d_source = 8'(SRC + srcoff);
         req = timed_out && j >= resp_at && j < d_delay;
         @(negedge clk);
         if (j == d_delay) check("d_ready", tl_h2d.d_ready, 1'b1);
         if (req) begin
            check("drain_no_gnt", gnt, 1'b0);
            check("drain_busy", busy, 1'b1);
         end
         check("rsp_valid", valid, j == resp_at);
         if (j == resp_at) begin
            check("rsp_err", err, exp_err);
            check("rsp_rdata", rdata, exp_rdata);
         end
         check("d_phase_no_a", tl_h2d.a_valid, 1'b0);
         @(posedge clk); #1;
      end
      tl_d2h.d_valid = 1'b0;
      req = 1'b0;
      sticky_exp = sticky_exp | bad;

      @(negedge clk);
      check("post_valid", valid, 1'b0);
      check("post_busy", busy, 1'b0);
      check("hold_rdata", rdata, exp_rdata);
      check("hold_err", err, exp_err);
      check("rsp_err_sticky", rsp_err, sticky_exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_err", err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_a_valid", tl_h2d.a_valid, 1'b0);
      check("rst_d_ready", tl_h2d.d_ready, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_txn(1'b0, 32'h1000_0007, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
      run_txn(1'b1, 32'h2000_0010, 32'h1234_5678, 4'h3, 4, 0, 32'h5555_AAAA, 1'b0, 0);
      run_txn(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'h0, 0, 0, 32'h0, 1'b0, 0);
      run_txn(1'b0, 32'h4000_0008, 32'h0, 4'hF, 0, 20, 32'h1111_2222, 1'b0, 0);
      run_txn(1'b0, 32'h4000_000C, 32'h0, 4'hF, 1, T - 1, 32'hCAFE_F00D, 1'b0, 0);
      run_txn(1'b0, 32'h5000_0004, 32'h0, 4'hF, 0, T, 32'h7777_7777, 1'b0, 0);
      run_txn(1'b0, 32'h6000_0000, 32'h0, 4'hF, 0, 1, 32'h0BAD_0BAD, 1'b1, 0);
      run_txn(1'b1, 32'h7000_0002, 32'hFEED_FACE, 4'hF, 2, 2, 32'h0, 1'b0, 0);
      run_txn(1'b0, 32'h8000_0000, 32'h0, 4'hF, 0, 0, 32'h1357_9BDF, 1'b0, 1);
      run_txn(1'b0, 32'h8000_0004, 32'h0, 4'hF, 0, 0, 32'h2468_ACE0, 1'b0, 0);

      // Reset while waiting for the D response.
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 32'h9000_0010; be = 4'hF; tl_d2h.a_ready = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      @(posedge clk); #1 tl_d2h.a_ready = 1'b0;
      @(negedge clk);
      check("arsp_busy", busy, 1'b1);
      check("arsp_d_ready", tl_h2d.d_ready, 1'b1);
      rst_n = 1'b0;
      #1;
      sticky_exp = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_valid", valid, 1'b0);
      check("mid_rst_rdata", rdata, 32'h0);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_rsp_err", rsp_err, 1'b0);
      check("mid_rst_a_d", {tl_h2d.a_valid, tl_h2d.d_ready}, 2'b00);
      @(posedge clk); #1 rst_n = 1'b1;
      run_txn(1'b0, 32'h9000_0014, 32'h0, 4'hF, 0, 0, 32'h600D_CAFE, 1'b0, 0);

      for (int n = 0; n < 30; n++) begin
         logic        rw;
         logic [3:0]  rb;
         int          dly;
         rw  = 1'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
         dly = ($urandom_range(0, 4) == 0) ? $urandom_range(T, T + 12) : $urandom_range(0, T - 1);
         run_txn(rw, $urandom, $urandom, rb, $urandom_range(0, 3), dly, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
